// File: rtl/matrix_result_collector.sv
// matrix_result_collector
//   Gathers M x N result elements that arrive in any order from a matrix
//   multiplier, then drains them row-major over a valid/ready stream.
//
//   Ports:
//     clk, rst_n              clock, asynchronous active-low reset
//     start                   begin a new collection, or abort the one in flight
//     c_data/c_row/c_col      incoming element and its position, qualified by c_valid
//     done                    multiplier finished; drain whatever has been collected
//     out_data/out_row/out_col/out_last/out_valid, out_ready
//                             drain stream; out_last marks element (M-1,N-1)
//     busy                    collector is not idle
//     complete                one-cycle pulse after the last element is accepted
//     err_dup                 sticky duplicate-write flag
//
//   Optional build macro: RESULT_COLLECTOR_DUP_CHECK_EN
//     When defined, a second write to an already-filled position sets err_dup.
//     When undefined, the second write overwrites silently and err_dup stays 0.
module matrix_result_collector #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned M          = 3,
    parameter int unsigned N          = 3,
    localparam int unsigned RW        = $clog2(M),
    localparam int unsigned CW        = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] c_data,
    input  logic [RW-1:0]         c_row,
    input  logic [CW-1:0]         c_col,
    input  logic                  c_valid,
    input  logic                  done,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [RW-1:0]         out_row,
    output logic [CW-1:0]         out_col,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  complete,
    output logic                  err_dup
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] store_q [M][N];
    logic [DATA_WIDTH-1:0] store_d [M][N];
    logic [M-1:0][N-1:0]   bitmap_q, bitmap_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    // out_row_q/out_col_q double as the drain pointer
    logic [RW-1:0]         out_row_q, out_row_d, nxt_row;
    logic [CW-1:0]         out_col_q, out_col_d, nxt_col;
    logic                  out_last_q, out_last_d;
    logic                  complete_q, complete_d;
    logic                  err_dup_q, err_dup_d;
    logic                  wr_hit;

    // Only in-range positions are written; others are dropped
    assign wr_hit = c_valid && (32'(c_row) < M) && (32'(c_col) < N);

    // Next-state, store update and drain output selection
    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        bitmap_d    = bitmap_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_last_d  = out_last_q;
        complete_d  = 1'b0;
        err_dup_d   = err_dup_q;
        nxt_row     = out_row_q;
        nxt_col     = out_col_q;

        if (start) begin
            // Start from any state: fresh, empty collection
            state_d     = ST_COLLECT;
            store_d     = '{default: '0};
            bitmap_d    = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_row_d   = '0;
            out_col_d   = '0;
            out_last_d  = 1'b0;
            err_dup_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_COLLECT: begin
                    if (wr_hit) begin
`ifdef RESULT_COLLECTOR_DUP_CHECK_EN
                        if (bitmap_q[c_row][c_col]) begin
                            err_dup_d = 1'b1;
                        end
`endif
                        store_d[c_row][c_col]  = c_data;
                        bitmap_d[c_row][c_col] = 1'b1;
                    end
                    // store_d already holds a same-cycle write, so element
                    // (0,0) is presented correctly on the first drain cycle
                    if (done || (&bitmap_d)) begin
                        state_d     = ST_DRAIN;
                        out_valid_d = 1'b1;
                        out_row_d   = '0;
                        out_col_d   = '0;
                        out_data_d  = store_d[out_row_d][out_col_d];
                        out_last_d  = ((M * N) == 1);
                    end
                end
                ST_DRAIN: begin
                    if (out_valid_q && out_ready) begin
                        if (out_last_q) begin
                            state_d     = ST_IDLE;
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                            out_data_d  = '0;
                            out_row_d   = '0;
                            out_col_d   = '0;
                            complete_d  = 1'b1;
                        end else begin
                            if (out_col_q == CW'(N - 1)) begin
                                nxt_col = '0;
                                nxt_row = out_row_q + 1'b1;
                            end else begin
                                nxt_col = out_col_q + 1'b1;
                            end
                            out_row_d  = nxt_row;
                            out_col_d  = nxt_col;
                            out_data_d = store_q[nxt_row][nxt_col];
                            out_last_d = (nxt_row == RW'(M - 1)) && (nxt_col == CW'(N - 1));
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            store_q     <= '{default: '0};
            bitmap_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
            complete_q  <= 1'b0;
            err_dup_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            bitmap_q    <= bitmap_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_last_q  <= out_last_d;
            complete_q  <= complete_d;
            err_dup_q   <= err_dup_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_last  = out_last_q;
    assign complete  = complete_q;
    assign err_dup   = err_dup_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_matrix_result_collector.sv
// Testbench for matrix_result_collector (3x3, 16-bit elements).
// A transaction-level model (element array + written flags + drain index)
// is checked against the DUT on every falling edge; directed scenarios add
// literal expectations on the drained element log.
module tb_matrix_result_collector;

    logic        clk = 1'b0;
    logic        rst_n, start, c_valid, done, out_ready;
    logic [15:0] c_data;
    logic [1:0]  c_row, c_col;
    logic [15:0] out_data;
    logic [1:0]  out_row, out_col;
    logic        out_valid, out_last, busy, complete, err_dup;

`ifdef RESULT_COLLECTOR_DUP_CHECK_EN
    localparam bit DUP_EN = 1'b1;
`else
    localparam bit DUP_EN = 1'b0;
`endif

    matrix_result_collector dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .c_data(c_data), .c_row(c_row), .c_col(c_col), .c_valid(c_valid), .done(done),
        .out_data(out_data), .out_row(out_row), .out_col(out_col), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .complete(complete),
        .err_dup(err_dup)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] drained[$];
    int          vcyc = 0;
    bit          seen_cmp = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: 0 idle, 1 collecting, 2 draining
    int          m_mode = 0;
    int          m_ptr = 0;
    bit          m_cmp = 1'b0;
    bit          m_err = 1'b0;
    logic [15:0] m_store [9];
    bit          m_wr [9];
    bit          all_w;
    int          idx;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_mode = 0; m_ptr = 0; m_cmp = 0; m_err = 0;
            for (int k = 0; k < 9; k++) begin m_store[k] = '0; m_wr[k] = 0; end
        end
        chk("busy", 32'(busy), 32'(m_mode != 0));
        chk("out_valid", 32'(out_valid), 32'(m_mode == 2));
        chk("complete", 32'(complete), 32'(m_cmp));
        chk("err_dup", 32'(err_dup), 32'(m_err));
        if (m_mode == 2) begin
            vcyc++;
            chk("out_data", 32'(out_data), 32'(m_store[m_ptr]));
            chk("out_row", 32'(out_row), 32'(m_ptr / 3));
            chk("out_col", 32'(out_col), 32'(m_ptr % 3));
            chk("out_last", 32'(out_last), 32'(m_ptr == 8));
        end else begin
            chk("out_last_idle", 32'(out_last), 32'h0);
        end
        if (complete) seen_cmp = 1'b1;
        if (rst_n) begin
            m_cmp = 0;
            if (start) begin
                m_mode = 1; m_ptr = 0; m_err = 0;
                for (int k = 0; k < 9; k++) begin m_store[k] = '0; m_wr[k] = 0; end
            end else if (m_mode == 1) begin
                if (c_valid && c_row < 2'd3 && c_col < 2'd3) begin
                    idx = int'(c_row) * 3 + int'(c_col);
                    if (m_wr[idx] && DUP_EN) m_err = 1;
                    m_store[idx] = c_data;
                    m_wr[idx] = 1;
                end
                all_w = 1'b1;
                for (int k = 0; k < 9; k++) if (!m_wr[k]) all_w = 1'b0;
                if (done || all_w) begin m_mode = 2; m_ptr = 0; end
            end else if (m_mode == 2 && out_ready) begin
                drained.push_back(out_data);
                if (m_ptr == 8) begin m_mode = 0; m_cmp = 1; end
                else m_ptr++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        drained.delete();
        vcyc = 0;
        seen_cmp = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic do_done();
        done = 1'b1; tick(); done = 1'b0;
    endtask

    task automatic wr(input int r, input int c, input logic [15:0] d, input bit dn);
        c_valid = 1'b1; c_row = 2'(r); c_col = 2'(c); c_data = d; done = dn;
        tick();
        c_valid = 1'b0; done = 1'b0;
    endtask

    task automatic drain_wait(input bit tog, input int budget);
        int n;
        n = 0;
        while (!seen_cmp && n < budget) begin
            tick();
            if (tog) out_ready = ~out_ready;
            n++;
        end
        chk("drain_timeout", 32'(seen_cmp), 32'h1);
        out_ready = 1'b1;
    endtask

    int ord_r [9] = '{2, 0, 1, 2, 0, 1, 2, 0, 1};
    int ord_c [9] = '{1, 0, 2, 2, 2, 0, 0, 1, 1};

    initial begin
        rst_n = 1'b0; start = 1'b0; c_valid = 1'b0; done = 1'b0; out_ready = 1'b1;
        c_data = '0; c_row = '0; c_col = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_complete", 32'(complete), 32'h0);

        // Out-of-order full 3x3, ready held high
        clear_log(); do_start();
        for (int i = 0; i < 9; i++)
            wr(ord_r[i], ord_c[i], 16'((ord_r[i] * 3 + ord_c[i] + 1) << 8), 1'b0);
        drain_wait(1'b0, 40);
        chk("full_count", 32'(drained.size()), 32'd9);
        chk("full_vcyc", 32'(vcyc), 32'd9);
        if (drained.size() == 9) begin
            chk("full_first", 32'(drained[0]), 32'h0100);
            chk("full_mid", 32'(drained[4]), 32'h0500);
            chk("full_last", 32'(drained[8]), 32'h0900);
        end
        chk("full_idle", 32'(busy), 32'h0);

        // Sparse write plus out-of-range drop, drained on done
        clear_log(); do_start();
        wr(0, 0, 16'h0200, 1'b0);
        wr(3, 1, 16'h7777, 1'b0);
        wr(2, 2, 16'h0300, 1'b0);
        do_done();
        drain_wait(1'b0, 40);
        chk("sparse_count", 32'(drained.size()), 32'd9);
        if (drained.size() == 9) begin
            chk("sparse_first", 32'(drained[0]), 32'h0200);
            chk("sparse_last", 32'(drained[8]), 32'h0300);
            for (int i = 1; i < 8; i++) chk("sparse_zero", 32'(drained[i]), 32'h0);
        end

        // Drain with out_ready alternating 1/0
        clear_log(); do_start();
        for (int i = 0; i < 9; i++) wr(i / 3, i % 3, 16'(16'h1000 + i), 1'b0);
        drain_wait(1'b1, 60);
        chk("stall_vcyc", 32'(vcyc), 32'd17);
        chk("stall_count", 32'(drained.size()), 32'd9);
        if (drained.size() == 9) chk("stall_elem4", 32'(drained[4]), 32'h1004);

        // Duplicate write to (1,1)
        clear_log(); do_start();
        wr(1, 1, 16'h0100, 1'b0);
        wr(1, 1, 16'h0500, 1'b0);
        chk("dup_flag", 32'(err_dup), 32'(DUP_EN));
        do_done();
        drain_wait(1'b0, 40);
        if (drained.size() == 9) chk("dup_value", 32'(drained[4]), 32'h0500);
        chk("dup_held", 32'(err_dup), 32'(DUP_EN));
        do_start();
        chk("dup_cleared", 32'(err_dup), 32'h0);

        // Abort mid-drain after 4 handshakes
        clear_log(); do_start();
        wr(0, 0, 16'h0A0A, 1'b0);
        wr(2, 2, 16'h0B0B, 1'b0);
        do_done();
        repeat (4) tick();
        chk("abort_hs", 32'(drained.size()), 32'd4);
        out_ready = 1'b0;
        do_start();
        chk("abort_busy", 32'(busy), 32'h1);
        chk("abort_valid", 32'(out_valid), 32'h0);
        clear_log();
        wr(0, 1, 16'h0700, 1'b0);
        do_done();
        out_ready = 1'b1;
        drain_wait(1'b0, 40);
        if (drained.size() == 9) begin
            chk("abort_e00", 32'(drained[0]), 32'h0);
            chk("abort_e01", 32'(drained[1]), 32'h0700);
            chk("abort_e22", 32'(drained[8]), 32'h0);
        end

        // Reset mid-collection
        do_start();
        wr(1, 0, 16'h1234, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 32'h0);
        chk("mrst_valid", 32'(out_valid), 32'h0);
        chk("mrst_data", 32'(out_data), 32'h0);
        chk("mrst_rowcol", 32'({out_row, out_col}), 32'h0);
        chk("mrst_last", 32'(out_last), 32'h0);
        chk("mrst_err", 32'(err_dup), 32'h0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("mrst_idle", 32'(busy), 32'h0);

        // Last element written in the same cycle as done
        clear_log(); do_start();
        for (int i = 0; i < 8; i++) wr(i / 3, i % 3, 16'(16'h2000 + i), 1'b0);
        wr(2, 2, 16'h2BCD, 1'b1);
        drain_wait(1'b0, 40);
        chk("same_count", 32'(drained.size()), 32'd9);
        if (drained.size() == 9) begin
            chk("same_e21", 32'(drained[7]), 32'h2007);
            chk("same_e22", 32'(drained[8]), 32'h2BCD);
        end

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
